// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: issues in-order word fetches over a req/gnt/rvalid
// interface, buffers responses in a small FIFO for decode, and restarts fetch at
// the branch/jump target, discarding any responses still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_B_J_result,
  input  logic [31:0] i_target_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_id_ready,
  output logic        o_misaligned
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] Credit = SumW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     resp_pc_q;
  logic [CntW-1:0] outstanding_q;
  logic [CntW-1:0] discard_q;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic            misaligned_q;

  logic [SumW-1:0] in_use;
  logic            req;
  logic            accept;
  logic            drop;
  logic            push;
  logic            pop;
  logic [CntW-1:0] outstanding_next;

  // Credit check, handshake decode and response routing.
  always_comb begin
    in_use           = {1'b0, outstanding_q} + {1'b0, count_q};
    req              = (state_q == StRun) && !i_B_J_result && (in_use < Credit);
    accept           = req && i_imem_gnt;
    // A response arriving in the redirect cycle is stale as well.
    drop             = i_imem_rvalid && (i_B_J_result || (discard_q != '0));
    push             = i_imem_rvalid && !drop;
    pop              = (count_q != '0) && i_id_ready && !i_B_J_result;
    outstanding_next = outstanding_q + CntW'(accept) - CntW'(i_imem_rvalid);
  end

  // Boot sequencing, PC tracking and in-flight/discard accounting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      if (state_q == StBoot) begin
        state_q <= StRun;
      end
      outstanding_q <= outstanding_next;
      misaligned_q  <= i_B_J_result && (i_target_pc[1:0] != 2'b00);
      if (i_B_J_result) begin
        fetch_pc_q <= {i_target_pc[31:2], 2'b00};
        resp_pc_q  <= {i_target_pc[31:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old stream.
        discard_q  <= outstanding_next;
      end else begin
        if (accept) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (i_imem_rvalid && (discard_q != '0)) begin
          discard_q <= discard_q - CntW'(1);
        end
      end
    end
  end

  // Instruction buffer; flushed on redirect, simultaneous push and pop allowed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
    end else if (i_B_J_result) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        fifo_instr_q[wr_ptr_q] <= i_imem_rdata;
        wr_ptr_q               <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Output drive; request must drop in the same cycle as a redirect.
  always_comb begin
    o_imem_req    = req;
    o_imem_addr   = fetch_pc_q;
    o_instr_valid = (count_q != '0);
    o_instr       = fifo_instr_q[rd_ptr_q];
    o_pc          = fifo_pc_q[rd_ptr_q];
    o_misaligned  = misaligned_q;
  end

`ifndef SYNTHESIS
  // Accounting stays inside the credit window by construction.
  a_rvalid_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_imem_rvalid |-> (outstanding_q != '0));
  a_credit_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      in_use <= Credit);
  a_discard_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      discard_q <= outstanding_q);
  a_fifo_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      push |-> ({1'b0, count_q} < Credit));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder with optional hold,
// logs of accepted fetch addresses and decode pops, checked against
// hand-computed sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bj = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        id_ready = 1'b1;
  logic        misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  logic        hold = 1'b0;
  logic [31:0] resp_addr;
  logic [31:0] pend[$];
  logic [31:0] acc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_B_J_result  (bj),
    .i_target_pc   (target),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_id_ready    (id_ready),
    .o_misaligned  (misaligned)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder and monitor, acting 2 time units before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        pend.delete();
        rvalid = 1'b0;
        rdata  = '0;
      end else begin
        if (instr_valid && id_ready && !bj) begin
          pop_pc.push_back(pc);
          pop_instr.push_back(instr);
        end
        if (!hold && (pend.size() > 0)) begin
          resp_addr = pend.pop_front();
          rvalid    = 1'b1;
          rdata     = mem(resp_addr);
        end else begin
          rvalid = 1'b0;
          rdata  = '0;
        end
        if (imem_req && gnt) begin
          pend.push_back(imem_addr);
          acc.push_back(imem_addr);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  task automatic do_reset(input logic ready);
    rst_n    = 1'b0;
    bj       = 1'b0;
    hold     = 1'b0;
    gnt      = 1'b1;
    id_ready = ready;
    cyc();
    cyc();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input string tag, input int n);
    for (int i = 0; (i < 200) && (acc.size() < n); i++) cyc();
    check(tag, acc.size(), n);
  endtask

  task automatic wait_pops(input string tag, input int n);
    for (int i = 0; (i < 200) && (pop_pc.size() < n); i++) cyc();
    check(tag, pop_pc.size(), n);
  endtask

  // Leaves n fetches consumed and the next two fetches held in flight, FIFO empty.
  task automatic setup_held(input int n);
    do_reset(1'b1);
    wait_acc("setup_acc", n);
    gnt = 1'b0;
    wait_pops("setup_pops", n);
    hold = 1'b1;
    gnt  = 1'b1;
    wait_acc("setup_held", n + 2);
  endtask

  initial begin
    // Reset state and first fetch latency.
    rst_n = 1'b0;
    cyc();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc, 0);
    check("rst_mis", misaligned, 0);
    do_reset(1'b1);
    check("boot_req", imem_req, 0);
    cyc();
    check("c1_valid", instr_valid, 0);
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 32'h0);
    cyc();
    check("c2_valid", instr_valid, 0);
    check("c2_addr", imem_addr, 32'h4);
    cyc();
    check("c3_valid", instr_valid, 1);
    check("c3_pc", pc, 32'h0);
    check("c3_instr", instr, mem(32'h0));
    wait_pops("t1_pops", 6);
    for (int i = 0; i < 3; i++) check("t1_acc", acc[i], 32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      check("t1_pop_pc", pop_pc[i], 32'(4 * i));
      check("t1_pop_instr", pop_instr[i], mem(32'(4 * i)));
    end

    // Decode stalled: credit stops fetch after two, nothing lost on release.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cyc();
    check("t2_acc_cnt", acc.size(), 2);
    check("t2_valid", instr_valid, 1);
    check("t2_pc", pc, 32'h0);
    check("t2_instr", instr, mem(32'h0));
    id_ready = 1'b1;
    wait_pops("t2_pops", 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_pc", pop_pc[i], 32'(4 * i));
      check("t2_pop_instr", pop_instr[i], mem(32'(4 * i)));
    end

    // Redirect with 0x8/0xC in flight.
    setup_held(2);
    check("t3_held_a", acc[2], 32'h8);
    check("t3_held_b", acc[3], 32'hC);
    clear_logs();
    bj     = 1'b1;
    target = 32'h100;
    #1;
    check("t3_req_drop", imem_req, 0);
    cyc();
    bj   = 1'b0;
    hold = 1'b0;
    check("t3_mis", misaligned, 0);
    check("t3_addr", imem_addr, 32'h100);
    wait_pops("t3_pops", 2);
    check("t3_pop0_pc", pop_pc[0], 32'h100);
    check("t3_pop0_instr", pop_instr[0], mem(32'h100));
    check("t3_pop1_pc", pop_pc[1], 32'h104);
    check("t3_acc0", acc[0], 32'h100);

    // Redirect coinciding with the 0x10 response, 0x14 still in flight.
    setup_held(4);
    clear_logs();
    bj     = 1'b1;
    target = 32'h200;
    hold   = 1'b0;
    cyc();
    bj = 1'b0;
    wait_pops("t4_pops", 2);
    check("t4_pop0_pc", pop_pc[0], 32'h200);
    check("t4_pop0_instr", pop_instr[0], mem(32'h200));
    check("t4_pop1_pc", pop_pc[1], 32'h204);
    check("t4_pop1_instr", pop_instr[1], mem(32'h204));
    check("t4_acc0", acc[0], 32'h200);

    // Misaligned redirect mid-stream.
    check("t5_mis_pre", misaligned, 0);
    clear_logs();
    bj     = 1'b1;
    target = 32'h103;
    cyc();
    bj = 1'b0;
    check("t5_mis_pulse", misaligned, 1);
    cyc();
    check("t5_mis_end", misaligned, 0);
    wait_pops("t5_pops", 1);
    check("t5_pop_pc", pop_pc[0], 32'h100);
    check("t5_pop_instr", pop_instr[0], mem(32'h100));
    check("t5_acc0", acc[0], 32'h100);

    // Asynchronous reset with the buffer full.
    id_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    check("t6_full_valid", instr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_instr", instr, 0);
    check("t6_rst_pc", pc, 0);
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_mis", misaligned, 0);
    cyc();
    clear_logs();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    wait_pops("t6_pops", 2);
    check("t6_acc0", acc[0], 32'h0);
    check("t6_pop0_pc", pop_pc[0], 32'h0);
    check("t6_pop0_instr", pop_instr[0], mem(32'h0));
    check("t6_pop1_pc", pop_pc[1], 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front-end. It is the consumer end of the branch/jump decision: it takes the execute-stage taken/redirect result and target, and steers the PC.
- Issues in-order word fetches to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- On redirect it discards stale in-flight responses and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2); also caps requests in flight plus buffered.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_B_J_result  in  1  redirect request from branch/jump control (1 = taken branch or jump).
- i_target_pc  in  32  redirect target, sampled when i_B_J_result=1.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  fetch word address.
- i_imem_gnt  in  1  request accepted (same-cycle with o_imem_req).
- i_imem_rvalid  in  1  response valid; responses return in order, >=1 cycle after gnt.
- i_imem_rdata  in  32  response instruction.
- o_instr_valid  out  1  FIFO head valid.
- o_instr  out  32  FIFO head instruction.
- o_pc  out  32  PC of FIFO head.
- i_id_ready  in  1  decode accepts head.
- o_misaligned  out  1  one-cycle pulse: redirect target had bits[1:0]!=0.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, discard=0, state=BOOT.
  - All outputs 0; o_imem_addr=RESET_PC.
- FSM:
  - BOOT: one idle cycle, then RUN.
  - RUN: normal fetch.
  - No other states; discard tracking is a counter, not a state.
- Request issue:
  - Condition: o_imem_req=1 when state=RUN, i_B_J_result=0 and outstanding+fifo_count < FIFO_DEPTH.
  - o_imem_addr=fetch_pc.
  - On req&gnt: fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding+=1.
  - req/gnt is a same-cycle accept. req may drop without gnt (redirect or credit); address changes only on gnt or redirect.
- Response:
  - On rvalid: outstanding-=1.
  - If discard>0: data dropped, discard-=1.
  - Else: push {resp_pc, rdata} into the FIFO and resp_pc+=4.
  - The credit rule guarantees a push never overflows the FIFO.
- Output:
  - FIFO head drives o_instr/o_pc; o_instr_valid=!empty.
  - Pop on o_instr_valid & i_id_ready.
  - Push and pop in the same cycle are both honored.
  - Latency: gnt at cycle N, rvalid at N+k -> o_instr_valid at N+k+1 (registered FIFO).
- Redirect (i_B_J_result=1, highest priority):
  - Same cycle: o_imem_req=0; pop suppressed.
  - Next edge: FIFO flushed; fetch_pc=resp_pc=i_target_pc & ~3.
  - discard = outstanding after this cycle's accounting: an rvalid in the redirect cycle is itself dropped and not counted.
  - Fetch at target resumes the following cycle.
  - o_misaligned=1 for one cycle if i_target_pc[1:0]!=0.
- Back-to-back redirects: the latest target wins; discard recomputed each time.
- Redirect during BOOT: target latched, state still moves to RUN.
- i_id_ready low: FIFO holds; requests stop once credit is exhausted; no data loss.
- Counters saturate-free: outstanding and discard are bounded by FIFO_DEPTH by construction. Assert (in simulation) on overflow or underflow.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after each gnt, id_ready=1 -> addresses 0x0,0x4,0x8...; first o_instr_valid at cycle 4 after reset release, o_pc=0x0, o_instr=mem[0].
- id_ready=0 for 10 cycles -> exactly 2 requests issued, FIFO holds pc 0x0/0x4. Release -> in-order pops, no drop or duplicate.
- Two requests outstanding (0x8,0xC), redirect to 0x100 -> both late responses dropped; next o_pc=0x100 with mem[0x100]; no output of 0x8/0xC.
- Redirect in the same cycle as an rvalid for 0x10 with one more outstanding -> both dropped; discard reaches 0 before the 0x200 data arrives; o_pc sequence 0x200,0x204.
- Redirect to 0x103 -> o_misaligned pulses for 1 cycle; fetch resumes at 0x100.
- Async reset asserted mid-stream with FIFO full -> outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale data.
